// File: rtl/async_pipeline_n_if.sv
// Bundled-data req/ack bus: upstream and downstream handshakes plus status of one pipeline.
// master drives requests, upstream data and downstream acks; slave is the pipeline itself.
interface async_pipeline_n_if #(
    parameter int DATA_W = 3,
    parameter int STAGES = 3
);
    localparam int OCC_W = $clog2(STAGES + 1);

    logic              req_in;
    logic [DATA_W-1:0] data_in;
    logic              ack_out;
    logic              req_out;
    logic [DATA_W-1:0] data_out;
    logic              ack_in;
    logic [OCC_W-1:0]  occupancy;
    logic              proto_err;

    modport master (
        output req_in, data_in, ack_in,
        input  ack_out, req_out, data_out, occupancy, proto_err
    );

    modport slave (
        input  req_in, data_in, ack_in,
        output ack_out, req_out, data_out, occupancy, proto_err
    );
endinterface

// File: rtl/async_pipeline_n.sv
// Clocked req/ack pipeline of STAGES registers, 2-phase or 4-phase; token reaches req_out STAGES-1 edges after accept.
// Backpressure: a full first stage freezes ack_out; a token moves only into a stage empty at edge start.
module async_pipeline_n #(
    parameter int DATA_W = 3,
    parameter int STAGES = 3,
    parameter int MODE   = 0
) (
    input  logic            clk,
    input  logic            rst,
    async_pipeline_n_if.slave bus
);
    localparam int OCC_W = $clog2(STAGES + 1);
    localparam int LAST  = STAGES - 1;

    logic [STAGES-1:0] full, full_n;
    logic [DATA_W-1:0] data   [STAGES];
    logic [DATA_W-1:0] data_n [STAGES];
    logic              ack_q, ack_n;
    logic              req_q, req_n;
    logic              ack_in_q, req_in_q;
    logic              err_q, err_n;
    logic [OCC_W-1:0]  occ_q, occ_n;
    logic              in_tok, accept, complete, last_blk, load_last;

    always_comb begin
        full_n    = full;
        data_n    = data;
        ack_n     = ack_q;
        req_n     = req_q;
        load_last = 1'b0;

        in_tok   = (MODE == 0) ? (bus.req_in != ack_q) : (bus.req_in & ~ack_q);
        // 4-phase: the last stage may not be reloaded until the consumer has returned ack to zero
        last_blk = (MODE != 0) && bus.ack_in;
        accept   = in_tok && !full[0] && !(STAGES == 1 && last_blk);
        complete = (MODE == 0) ? (full[LAST] && (bus.ack_in == req_q))
                               : (req_q && bus.ack_in);

        if (complete) begin
            full_n[LAST] = 1'b0;
            if (MODE != 0)
                req_n = 1'b0;
        end

        if (accept) begin
            data_n[0] = bus.data_in;
            full_n[0] = 1'b1;
            ack_n     = ~ack_q;
            if (STAGES == 1)
                load_last = 1'b1;
        end else if (MODE != 0 && !bus.req_in && ack_q) begin
            ack_n = 1'b0;
        end

        for (int i = 0; i < STAGES - 1; i++) begin
            if (full[i] && !full[i+1] && !((i + 1 == LAST) && last_blk)) begin
                data_n[i+1] = data[i];
                full_n[i+1] = 1'b1;
                full_n[i]   = 1'b0;
                if (i + 1 == LAST)
                    load_last = 1'b1;
            end
        end

        if (load_last)
            req_n = (MODE == 0) ? ~req_q : 1'b1;

        if (MODE == 0)
            err_n = err_q | ((bus.ack_in != ack_in_q) && (req_q == ack_in_q));
        else
            err_n = err_q | (req_in_q && !bus.req_in && !ack_q)
                          | (bus.ack_in && !ack_in_q && !req_q);

        occ_n = '0;
        for (int i = 0; i < STAGES; i++)
            occ_n = occ_n + OCC_W'(full_n[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full     <= '0;
            for (int i = 0; i < STAGES; i++)
                data[i] <= '0;
            ack_q    <= 1'b0;
            req_q    <= 1'b0;
            ack_in_q <= 1'b0;
            req_in_q <= 1'b0;
            err_q    <= 1'b0;
            occ_q    <= '0;
        end else begin
            full     <= full_n;
            data     <= data_n;
            ack_q    <= ack_n;
            req_q    <= req_n;
            ack_in_q <= bus.ack_in;
            req_in_q <= bus.req_in;
            err_q    <= err_n;
            occ_q    <= occ_n;
        end
    end

    assign bus.ack_out   = ack_q;
    assign bus.req_out   = req_q;
    assign bus.data_out  = data[LAST];
    assign bus.occupancy = occ_q;
    assign bus.proto_err = err_q;
endmodule

// File: tb/tb_async_pipeline_n.sv
// Directed bench: a 2-phase 3-stage pipeline and a 4-phase 2-stage pipeline on one clock.
module tb_async_pipeline_n;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    async_pipeline_n_if #(.DATA_W(3), .STAGES(3)) a ();
    async_pipeline_n_if #(.DATA_W(3), .STAGES(2)) b ();

    async_pipeline_n #(.DATA_W(3), .STAGES(3), .MODE(0)) dut_a (.clk(clk), .rst(rst), .bus(a));
    async_pipeline_n #(.DATA_W(3), .STAGES(2), .MODE(1)) dut_b (.clk(clk), .rst(rst), .bus(b));

    logic [2:0] vals2 [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [2:0] vals3 [4] = '{3'd6, 3'd7, 3'd2, 3'd3};
    logic [2:0] got   [4];
    int         ns, ng, lat;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        a.req_in = 1'b0; a.data_in = '0; a.ack_in = 1'b0;
        b.req_in = 1'b0; b.data_in = '0; b.ack_in = 1'b0;
        rst = 1'b1;
        cyc; cyc;
        chk("rst_a_ack",  a.ack_out,   0);
        chk("rst_a_req",  a.req_out,   0);
        chk("rst_a_occ",  a.occupancy, 0);
        chk("rst_a_err",  a.proto_err, 0);
        chk("rst_a_dout", a.data_out,  0);
        chk("rst_b_req",  b.req_out,   0);
        chk("rst_b_occ",  b.occupancy, 0);
        rst = 1'b0;

        // single token through the 2-phase pipeline
        a.data_in = 3'd1; a.req_in = 1'b1;
        cyc;
        chk("t1_ack",     a.ack_out,   1);
        chk("t1_occ",     a.occupancy, 1);
        chk("t1_req0",    a.req_out,   0);
        cyc;
        chk("t1_req_mid", a.req_out,   0);
        cyc;
        chk("t1_req",     a.req_out,   1);
        chk("t1_dout",    a.data_out,  1);
        a.ack_in = 1'b1;
        cyc;
        chk("t1_occ_done", a.occupancy, 0);
        chk("t1_err",      a.proto_err, 0);

        // stream with a prompt consumer
        ns = 0; ng = 0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            if (ns < 4 && a.req_in == a.ack_out) begin
                a.data_in = vals2[ns];
                a.req_in  = ~a.req_in;
                ns++;
            end
            if (a.req_out != a.ack_in) begin
                got[ng]  = a.data_out;
                ng++;
                a.ack_in = a.req_out;
            end
            cyc;
        end
        chk("t2_count", ng, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t2_data%0d", i), got[i], vals2[i]);
        chk("t2_occ", a.occupancy, 0);
        chk("t2_err", a.proto_err, 0);

        // consumer stalls: pipeline fills, fourth token waits
        ns = 0;
        for (int c = 0; c < 20; c++) begin
            if (ns < 4 && a.req_in == a.ack_out) begin
                a.data_in = vals3[ns];
                a.req_in  = ~a.req_in;
                ns++;
            end
            cyc;
        end
        chk("t3_sent",    ns, 4);
        chk("t3_occ",     a.occupancy, 3);
        chk("t3_stall",   a.req_in != a.ack_out, 1);
        chk("t3_pending", a.req_out != a.ack_in, 1);
        chk("t3_dout",    a.data_out, 6);
        a.ack_in = a.req_out;
        lat = 0;
        for (int c = 0; c < 8 && a.req_in != a.ack_out; c++) begin
            cyc;
            lat++;
        end
        chk("t3_accept",    a.req_in == a.ack_out, 1);
        chk("t3_lat",       lat, 4);
        chk("t3_occ_after", a.occupancy, 3);
        chk("t3_dout2",     a.data_out, 7);

        // reset with two tokens in flight
        a.ack_in = a.req_out;
        cyc;
        chk("t6_occ2", a.occupancy, 2);
        rst = 1'b1; a.req_in = 1'b0; a.ack_in = 1'b0;
        cyc;
        chk("t6_ack",  a.ack_out,   0);
        chk("t6_req",  a.req_out,   0);
        chk("t6_occ",  a.occupancy, 0);
        chk("t6_dout", a.data_out,  0);
        rst = 1'b0;
        repeat (4) cyc;
        chk("t6_no_req",   a.req_out,   0);
        chk("t6_occ_idle", a.occupancy, 0);

        // 2-phase ack with nothing pending
        a.ack_in = 1'b1;
        cyc;
        chk("t5_err", a.proto_err, 1);
        a.ack_in = 1'b0;
        cyc; cyc;
        chk("t5_err_sticky", a.proto_err, 1);
        rst = 1'b1; a.req_in = 1'b1; a.data_in = 3'd5;
        cyc;
        chk("t5_err_clr", a.proto_err, 0);
        rst = 1'b0;
        cyc;
        chk("t5_held_req_ack", a.ack_out,   1);
        chk("t5_held_req_occ", a.occupancy, 1);

        // 4-phase handshake
        b.data_in = 3'd5; b.req_in = 1'b1;
        cyc;
        chk("b_ack",  b.ack_out,   1);
        chk("b_occ",  b.occupancy, 1);
        chk("b_req0", b.req_out,   0);
        b.req_in = 1'b0;
        cyc;
        chk("b_ack_rz", b.ack_out,  0);
        chk("b_req",    b.req_out,  1);
        chk("b_dout",   b.data_out, 5);
        b.ack_in = 1'b1;
        cyc;
        chk("b_req_done", b.req_out,   0);
        chk("b_occ_done", b.occupancy, 0);
        b.data_in = 3'd3; b.req_in = 1'b1;
        cyc;
        chk("b_ack2", b.ack_out, 1);
        b.req_in = 1'b0;
        cyc;
        chk("b_blocked_req", b.req_out,   0);
        chk("b_blocked_occ", b.occupancy, 1);
        b.ack_in = 1'b0;
        cyc;
        chk("b_req2",  b.req_out,  1);
        chk("b_dout2", b.data_out, 3);
        b.ack_in = 1'b1;
        cyc;
        b.ack_in = 1'b0;
        cyc;
        chk("b_occ_end", b.occupancy, 0);
        chk("b_err0",    b.proto_err, 0);

        // 4-phase: request withdrawn before it was acknowledged
        b.data_in = 3'd1; b.req_in = 1'b1;
        cyc;
        b.req_in = 1'b0;
        cyc;
        b.data_in = 3'd2; b.req_in = 1'b1;
        cyc;
        b.req_in = 1'b0;
        cyc;
        chk("b_full_occ", b.occupancy, 2);
        b.req_in = 1'b1;
        cyc;
        chk("b_stall_ack", b.ack_out,   0);
        chk("b_err_pre",   b.proto_err, 0);
        b.req_in = 1'b0;
        cyc;
        chk("b_err_drop",  b.proto_err, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
